// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, bubble insertion and operand forwarding
// control for a 5-stage RV32I pipeline. A registered shadow of the ID/EX,
// EX/MEM and MEM/WB instructions (register fields plus class flags) drives
// purely combinational decisions for the instruction currently in decode.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the decode
// fields for the current cycle; mem_stall is a global freeze that overrides
// everything; flush discards the decode instruction. The load_use_stall output
// is a same-cycle request to hold PC and IF/ID and to inject a bubble.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             load_use_stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_store_fwd,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  // One shadow entry per pipeline stage; all-zero is a bubble.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr;
    logic       ld;
    logic       st;
    logic       use1;
    logic       use2;
  } stage_t;

  stage_t dec_raw;   // class flags of the decode opcode, ignoring id_valid
  stage_t dec;       // entry that enters ID/EX on a normal advance
  stage_t idex;
  stage_t exmem;
  stage_t memwb;
  logic   hazard;

  // Classify the decode opcode; rd == x0 never counts as a write.
  always_comb begin
    dec_raw      = '0;
    dec_raw.rd   = id_rd;
    dec_raw.rs1  = id_rs1;
    dec_raw.rs2  = id_rs2;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: dec_raw.wr = 1'b1;
      OP_JALR: begin
        dec_raw.wr   = 1'b1;
        dec_raw.use1 = 1'b1;
      end
      OP_BR: begin
        dec_raw.use1 = 1'b1;
        dec_raw.use2 = 1'b1;
      end
      OP_LOAD: begin
        dec_raw.wr   = 1'b1;
        dec_raw.ld   = 1'b1;
        dec_raw.use1 = 1'b1;
      end
      OP_STORE: begin
        dec_raw.st   = 1'b1;
        dec_raw.use1 = 1'b1;
        dec_raw.use2 = 1'b1;
      end
      OP_IMM: begin
        dec_raw.wr   = 1'b1;
        dec_raw.use1 = 1'b1;
      end
      OP_REG: begin
        dec_raw.wr   = 1'b1;
        dec_raw.use1 = 1'b1;
        dec_raw.use2 = 1'b1;
      end
      default: ;
    endcase
    if (id_rd == 5'd0) dec_raw.wr = 1'b0;
    dec       = dec_raw;
    dec.valid = 1'b1;
    if (!id_valid) dec = '0;
  end

  // Load in ID/EX feeding decode. A store's rs2 is excluded because the
  // load data reaches it later through mem_store_fwd.
  always_comb begin
    hazard = idex.valid && idex.ld && (idex.rd != 5'd0) && id_valid &&
             ((dec_raw.use1 && (id_rs1 == idex.rd)) ||
              (dec_raw.use2 && !dec_raw.st && (id_rs2 == idex.rd)));
    load_use_stall = hazard && !flush && !mem_stall;
  end

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet.
  function automatic logic [1:0] fwd_pick(input logic used, input logic [4:0] rs,
                                          input stage_t em, input stage_t mw);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used && (rs != 5'd0)) begin
      if (em.valid && em.wr && !em.ld && (em.rd == rs)) sel = SEL_EXM;
      else if (mw.valid && mw.wr && (mw.rd == rs))      sel = SEL_MWB;
    end
    return sel;
  endfunction

  // Forwarding selects for the instruction in EX and the MEM-stage store data.
  always_comb begin
    fwd_a_sel     = fwd_pick(idex.use1, idex.rs1, exmem, memwb);
    fwd_b_sel     = fwd_pick(idex.use2, idex.rs2, exmem, memwb);
    mem_store_fwd = exmem.valid && exmem.st && memwb.valid && memwb.ld &&
                    (memwb.rd == exmem.rs2) && (memwb.rd != 5'd0);
  end

  // Shadow pipeline advance: freeze, bubble-insert, or normal shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else if (mem_stall) begin
      idex  <= idex;
      exmem <= exmem;
      memwb <= memwb;
    end else if (load_use_stall || flush) begin
      idex  <= '0;
      exmem <= idex;
      memwb <= exmem;
    end else begin
      idex  <= dec;
      exmem <= idex;
      memwb <= exmem;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (load_use_stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Two instances share the stimulus:
// one at the default counter width and one with CNT_W=2 for saturation.
// Each driven cycle pushes its hand-derived expected outputs to exp_q; the
// monitor pops and compares on the falling edge of the same cycle.
module tb_hazard_stall_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam int         W        = 24;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        mem_stall, flush;
  logic        load_use_stall, mem_store_fwd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;
  logic        lus_s, msf_s;
  logic [1:0]  fa_s, fb_s;
  logic [1:0]  cnt_s;

  logic [W-1:0] exp_q[$];
  string        cur_tag;
  int           total;
  int           bad;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_stall(mem_stall), .flush(flush),
    .load_use_stall(load_use_stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_store_fwd(mem_store_fwd), .stall_count(stall_count)
  );

  hazard_stall_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_stall(mem_stall), .flush(flush),
    .load_use_stall(lus_s), .fwd_a_sel(fa_s), .fwd_b_sel(fb_s),
    .mem_store_fwd(msf_s), .stall_count(cnt_s)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Scoreboard: compare the cycle's outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({cur_tag, "/stall"}, {31'd0, load_use_stall}, {31'd0, e[23]});
      check({cur_tag, "/fwd_a"}, {30'd0, fwd_a_sel},      {30'd0, e[22:21]});
      check({cur_tag, "/fwd_b"}, {30'd0, fwd_b_sel},      {30'd0, e[20:19]});
      check({cur_tag, "/st_fwd"}, {31'd0, mem_store_fwd}, {31'd0, e[18]});
      check({cur_tag, "/count"}, {16'd0, stall_count},    {16'd0, e[17:2]});
      check({cur_tag, "/count_sat"}, {30'd0, cnt_s},      {30'd0, e[1:0]});
    end
  end

  // Driver: apply one cycle of inputs just after the rising edge and queue
  // the expected outputs for that cycle.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic ms, input logic fl,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb,
                      input logic esf, input int ecnt);
    logic [1:0] esat;
    @(posedge clk);
    #1;
    rst       = r;
    id_valid  = v;
    id_opcode = op;
    id_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
    mem_stall = ms;
    flush     = fl;
    cur_tag   = tag;
    esat      = (ecnt > 3) ? 2'd3 : ecnt[1:0];
    exp_q.push_back({es, ea, eb, esf, ecnt[15:0], esat});
  endtask

  task automatic op_step(input string tag, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic es, input logic [1:0] ea, input logic [1:0] eb,
                         input logic esf, input int ecnt);
    step(tag, 1'b0, 1'b1, op, rd, rs1, rs2, 1'b0, 1'b0, es, ea, eb, esf, ecnt);
  endtask

  task automatic nop_step(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                          input logic esf, input int ecnt);
    logic [6:0] junk_op;
    logic [4:0] junk_r;
    junk_op = 7'($urandom_range(0, 127));
    junk_r  = 5'($urandom_range(0, 31));
    step(tag, 1'b0, 1'b0, junk_op, junk_r, junk_r, junk_r, 1'b0, 1'b0, 1'b0, ea, eb, esf, ecnt);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; id_valid = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cur_tag = "init";
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    mem_stall = 1'b0; flush = 1'b0;

    // Reset values while rst is held
    step("reset", 1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    do_reset();

    // Load then dependent use: one stall, then MEM/WB forward
    op_step("a_load",  OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("a_stall", OP_REG,  5'd6, 5'd5, 5'd4, 1'b1, 2'd0, 2'd0, 1'b0, 0);
    op_step("a_go",    OP_REG,  5'd6, 5'd5, 5'd4, 1'b0, 2'd0, 2'd0, 1'b0, 1);
    nop_step("a_ex",   2'd2, 2'd0, 1'b0, 1);
    nop_step("a_tail", 2'd0, 2'd0, 1'b0, 1);

    // ALU chain: EX/MEM forward, then MEM/WB forward
    do_reset();
    op_step("b_imm",  OP_IMM, 5'd3, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("b_reg",  OP_REG, 5'd8, 5'd3, 5'd3, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("b_next", OP_IMM, 5'd9, 5'd3, 5'd0, 1'b0, 2'd1, 2'd1, 1'b0, 0);
    nop_step("b_wb",  2'd2, 2'd0, 1'b0, 0);

    // Both later stages write x3: EX/MEM must win
    do_reset();
    op_step("p_imm1", OP_IMM, 5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("p_imm2", OP_IMM, 5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("p_reg",  OP_REG, 5'd10, 5'd3, 5'd3, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("p_ex",  2'd1, 2'd1, 1'b0, 0);

    // Load then store data: no stall, store-data forward in MEM
    do_reset();
    op_step("c_load",  OP_LOAD,  5'd7, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("c_store", OP_STORE, 5'd5, 5'd2, 5'd7, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("c_ex",   2'd0, 2'd0, 1'b0, 0);
    nop_step("c_mem",  2'd0, 2'd0, 1'b1, 0);
    nop_step("c_tail", 2'd0, 2'd0, 1'b0, 0);

    // Store address from a load must stall
    do_reset();
    op_step("c2_load",  OP_LOAD,  5'd7, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("c2_stall", OP_STORE, 5'd0, 5'd7, 5'd3, 1'b1, 2'd0, 2'd0, 1'b0, 0);
    op_step("c2_go",    OP_STORE, 5'd0, 5'd7, 5'd3, 1'b0, 2'd0, 2'd0, 1'b0, 1);
    nop_step("c2_ex",   2'd2, 2'd0, 1'b0, 1);

    // x0 load target and x0 reader
    do_reset();
    op_step("d1_load", OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("d1_use",  OP_REG,  5'd4, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("d1_ex",  2'd0, 2'd0, 1'b0, 0);

    // Branch is not a writer (EX/MEM position)
    do_reset();
    op_step("d3_br",  OP_BR,  5'd6, 5'd1, 5'd2, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("d3_use", OP_REG, 5'd7, 5'd6, 5'd6, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("d3_ex", 2'd0, 2'd0, 1'b0, 0);

    // CSR is not a writer (MEM/WB position)
    do_reset();
    op_step("d4_csr", OP_CSR, 5'd6, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("d4_gap", 2'd0, 2'd0, 1'b0, 0);
    op_step("d4_use", OP_REG, 5'd7, 5'd6, 5'd6, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("d4_ex", 2'd0, 2'd0, 1'b0, 0);

    // Freeze during a hazard: nothing moves, stall comes after release
    do_reset();
    op_step("e_imm",  OP_IMM,  5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("e_load", OP_LOAD, 5'd5, 5'd3, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      step("e_freeze", 1'b0, 1'b1, OP_REG, 5'd6, 5'd5, 5'd2, 1'b1, 1'b0,
           1'b0, 2'd1, 2'd0, 1'b0, 0);
    op_step("e_stall", OP_REG, 5'd6, 5'd5, 5'd2, 1'b1, 2'd1, 2'd0, 1'b0, 0);
    op_step("e_go",    OP_REG, 5'd6, 5'd5, 5'd2, 1'b0, 2'd0, 2'd0, 1'b0, 1);
    nop_step("e_ex",   2'd2, 2'd0, 1'b0, 1);

    // Hazard plus flush: no stall, no count
    do_reset();
    op_step("f_load", OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    step("f_flush", 1'b0, 1'b1, OP_REG, 5'd6, 5'd5, 5'd4, 1'b0, 1'b1,
         1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("f_after", 2'd0, 2'd0, 1'b0, 0);
    nop_step("f_tail",  2'd0, 2'd0, 1'b0, 0);

    // Flushed decode must become a bubble, not a forwarding consumer
    do_reset();
    op_step("f2_imm", OP_IMM, 5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    step("f2_flush", 1'b0, 1'b1, OP_REG, 5'd8, 5'd3, 5'd3, 1'b0, 1'b1,
         1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("f2_bubble", 2'd0, 2'd0, 1'b0, 0);

    // Reset asserted mid-stall clears everything at once
    do_reset();
    op_step("g_load",  OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("g_stall", OP_REG,  5'd6, 5'd5, 5'd4, 1'b1, 2'd0, 2'd0, 1'b0, 0);
    step("g_rst", 1'b1, 1'b1, OP_REG, 5'd6, 5'd5, 5'd4, 1'b0, 1'b0,
         1'b0, 2'd0, 2'd0, 1'b0, 0);
    op_step("g_post", OP_REG, 5'd6, 5'd5, 5'd4, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    nop_step("g_ex",  2'd0, 2'd0, 1'b0, 0);

    // Five stalls: wide counter reaches 5, 2-bit counter holds at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op_step("h_load",  OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, i);
      op_step("h_stall", OP_REG,  5'd6, 5'd5, 5'd4, 1'b1, 2'd0, 2'd0, 1'b0, i);
      op_step("h_go",    OP_REG,  5'd6, 5'd5, 5'd4, 1'b0, 2'd0, 2'd0, 1'b0, i + 1);
      nop_step("h_ex",   2'd2, 2'd0, 1'b0, i + 1);
      nop_step("h_tail", 2'd0, 2'd0, 1'b0, i + 1);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
